multi_channel_counter: RTL and testbench

//  Bank of P_NCHAN independent programmable up/down counters: per-channel min/max range,

---
 rtl/multi_channel_counter_pkg.sv | 20 ++
 rtl/multi_channel_counter_channel.sv | 74 +++++++
 rtl/multi_channel_counter.sv | 77 +++++++
 tb/tb_multi_channel_counter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_counter_pkg.sv
// Shared encodings and default widths for the multi-channel counter bank.
package multi_channel_counter_pkg;

  localparam int unsigned CNT_DEF_NBITS      = 32;
  localparam int unsigned CNT_DEF_NCHAN      = 4;
  localparam int unsigned CNT_DEF_PRESCALE_W = 8;

  // Count direction as driven on inc_dec.
  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Limit behaviour as driven on sat_mode.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage : multi_channel_counter_pkg

// File: rtl/multi_channel_counter_channel.sv
// counter_channel: one programmable up/down counter with min/max range,
// wrap/saturate limit handling, clr/load and a registered terminal-count pulse.
module counter_channel
  import multi_channel_counter_pkg::*;
#(
  parameter int unsigned P_NBITS = CNT_DEF_NBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               cnten,
  input  logic               inc_dec,
  input  logic               sat_mode,
  input  logic               clr,
  input  logic               load,
  input  logic [P_NBITS-1:0] load_val,
  input  logic [P_NBITS-1:0] cnt_min,
  input  logic [P_NBITS-1:0] cnt_max,
  output logic [P_NBITS-1:0] cnt_value,
  output logic               tc,
  output logic               at_limit,
  output logic               cfg_err
);

  localparam logic [P_NBITS-1:0] ONE = {{(P_NBITS-1){1'b0}}, 1'b1};

  logic [P_NBITS-1:0] cnt_q, cnt_d;
  logic               tc_q, tc_d;
  logic               up, sat, hit, cnt_evt;

  // Next-state: priority clr > load > count event > hold; limit compare fires
  // before the +/-1 so a bound at zero or all-ones never overflows.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    cnt_d    = cnt_q;
    tc_d     = 1'b0;
    up       = (cnt_dir_e'(inc_dec) == CNT_UP);
    sat      = (cnt_mode_e'(sat_mode) == CNT_SAT);
    cfg_err  = (cnt_min > cnt_max);
    hit      = up ? (cnt_q >= cnt_max) : (cnt_q <= cnt_min);
    at_limit = hit;
    cnt_evt  = cnten & tick & ~cfg_err;

    if (clr) begin
      cnt_d = up ? cnt_min : cnt_max;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_evt) begin
      if (hit) begin
        tc_d = 1'b1;
        if (up) cnt_d = sat ? cnt_max : cnt_min;
        else    cnt_d = sat ? cnt_min : cnt_max;
      end else begin
        cnt_d = up ? (cnt_q + ONE) : (cnt_q - ONE);
      end
    end
  end

  // Count and terminal-count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt_value = cnt_q;
  assign tc        = tc_q;

endmodule : counter_channel

// File: rtl/multi_channel_counter.sv
// multi_channel_counter: bank of P_NCHAN independent counter_channel instances
// sharing one optional tick prescaler.
// Optional feature: define COUNTER_PRESCALE_EN to enable the shared prescaler;
// without it every cycle is a tick and prescale_div is ignored.
module multi_channel_counter
  import multi_channel_counter_pkg::*;
#(
  parameter int unsigned P_NBITS      = CNT_DEF_NBITS,
  parameter int unsigned P_NCHAN      = CNT_DEF_NCHAN,
  parameter int unsigned P_PRESCALE_W = CNT_DEF_PRESCALE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [P_NCHAN-1:0]         cnten,
  input  logic [P_NCHAN-1:0]         inc_dec,
  input  logic [P_NCHAN-1:0]         sat_mode,
  input  logic [P_NCHAN-1:0]         clr,
  input  logic [P_NCHAN-1:0]         load,
  input  logic [P_NCHAN*P_NBITS-1:0] load_val,
  input  logic [P_NCHAN*P_NBITS-1:0] cnt_min,
  input  logic [P_NCHAN*P_NBITS-1:0] cnt_max,
  input  logic [P_PRESCALE_W-1:0]    prescale_div,
  output logic [P_NCHAN*P_NBITS-1:0] cnt_value,
  output logic [P_NCHAN-1:0]         tc,
  output logic [P_NCHAN-1:0]         at_limit,
  output logic [P_NCHAN-1:0]         cfg_err
);

  logic tick;

`ifdef COUNTER_PRESCALE_EN
  localparam logic [P_PRESCALE_W-1:0] PS_ONE = {{(P_PRESCALE_W-1){1'b0}}, 1'b1};

  logic [P_PRESCALE_W-1:0] presc_q, presc_d;

  // Free-running 0..prescale_div counter; tick on the terminal value. The >=
  // compare recovers immediately if prescale_div is lowered below the count.
  always_comb begin
    tick    = (presc_q >= prescale_div);
    presc_d = tick ? '0 : (presc_q + PS_ONE);
  end

  // Prescaler register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end
`else
  logic unused_prescale_div;

  assign tick                = 1'b1;
  assign unused_prescale_div = ^prescale_div;
`endif

  for (genvar g = 0; g < P_NCHAN; g++) begin : g_chan
    counter_channel #(
      .P_NBITS (P_NBITS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .cnten     (cnten[g]),
      .inc_dec   (inc_dec[g]),
      .sat_mode  (sat_mode[g]),
      .clr       (clr[g]),
      .load      (load[g]),
      .load_val  (load_val[g*P_NBITS +: P_NBITS]),
      .cnt_min   (cnt_min[g*P_NBITS +: P_NBITS]),
      .cnt_max   (cnt_max[g*P_NBITS +: P_NBITS]),
      .cnt_value (cnt_value[g*P_NBITS +: P_NBITS]),
      .tc        (tc[g]),
      .at_limit  (at_limit[g]),
      .cfg_err   (cfg_err[g])
    );
  end

endmodule : multi_channel_counter

// File: tb/tb_multi_channel_counter.sv
// Directed self-checking bench for multi_channel_counter (default parameters).
module tb_multi_channel_counter;

  localparam int NB = 32;
  localparam int NC = 4;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    cnten, inc_dec, sat_mode, clr, load;
  logic [NC*NB-1:0] load_val, cnt_min, cnt_max;
  logic [PW-1:0]    prescale_div;
  logic [NC*NB-1:0] cnt_value;
  logic [NC-1:0]    tc, at_limit, cfg_err;

  int n_pass = 0;
  int n_total = 0;

  multi_channel_counter #(
    .P_NBITS      (NB),
    .P_NCHAN      (NC),
    .P_PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cnten        (cnten),
    .inc_dec      (inc_dec),
    .sat_mode     (sat_mode),
    .clr          (clr),
    .load         (load),
    .load_val     (load_val),
    .cnt_min      (cnt_min),
    .cnt_max      (cnt_max),
    .prescale_div (prescale_div),
    .cnt_value    (cnt_value),
    .tc           (tc),
    .at_limit     (at_limit),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  // One clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [NB-1:0] cv(int ch);
    return cnt_value[ch*NB +: NB];
  endfunction

  task automatic cfg(int ch, logic [NB-1:0] mn, logic [NB-1:0] mx, logic up, logic sat);
    cnt_min[ch*NB +: NB] = mn;
    cnt_max[ch*NB +: NB] = mx;
    inc_dec[ch]          = up;
    sat_mode[ch]         = sat;
  endtask

  task automatic test_reset();
    reset = 1'b1; cnten = '0; inc_dec = '0; sat_mode = '0; clr = '0; load = '0;
    load_val = '0; cnt_min = '0; cnt_max = '0; prescale_div = '0;
    step(); step();
    n_total++;
    if (cnt_value !== '0 || tc !== '0)
      $display("FAIL reset_state cnt=%0h tc=%b exp cnt=0 tc=0", cnt_value, tc);
    else n_pass++;
    reset = 1'b0;
    cfg(0, 0, 9, 1'b1, 1'b0);
    load[0] = 1'b1; load_val[0 +: NB] = 5;
    step();
    load[0] = 1'b0; cnten[0] = 1'b1;
    n_total++;
    if (cv(0) !== 5) $display("FAIL reset_load cnt=%0d exp 5", cv(0));
    else n_pass++;
    step();
    n_total++;
    if (cv(0) !== 6) $display("FAIL reset_count cnt=%0d exp 6", cv(0));
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0; cnten[0] = 1'b0;
    n_total++;
    if (cv(0) !== 0 || tc[0] !== 1'b0)
      $display("FAIL reset_midcount cnt=%0d tc=%b exp cnt=0 tc=0", cv(0), tc[0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [NB-1:0] exp_c [4] = '{4, 5, 6, 3};
    logic          exp_t [4] = '{0, 0, 0, 1};
    cfg(0, 3, 6, 1'b1, 1'b0);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    n_total++;
    if (cv(0) !== 3) $display("FAIL wrap_clr cnt=%0d exp 3", cv(0));
    else n_pass++;
    cnten[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (cv(0) !== exp_c[i] || tc[0] !== exp_t[i])
        $display("FAIL wrap_up[%0d] cnt=%0d tc=%b exp cnt=%0d tc=%b", i, cv(0), tc[0], exp_c[i], exp_t[i]);
      else n_pass++;
      if (i == 2) begin
        n_total++;
        if (at_limit[0] !== 1'b1) $display("FAIL wrap_at_limit got %b exp 1", at_limit[0]);
        else n_pass++;
      end
    end
    inc_dec[0] = 1'b0;
    step();
    n_total++;
    if (cv(0) !== 6 || tc[0] !== 1'b1)
      $display("FAIL wrap_down cnt=%0d tc=%b exp cnt=6 tc=1", cv(0), tc[0]);
    else n_pass++;
    step();
    cnten[0] = 1'b0;
    n_total++;
    if (cv(0) !== 5 || tc[0] !== 1'b0)
      $display("FAIL wrap_down2 cnt=%0d tc=%b exp cnt=5 tc=0", cv(0), tc[0]);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [NB-1:0] exp_c [7] = '{1, 2, 2, 2, 1, 0, 0};
    logic          exp_t [7] = '{0, 0, 1, 1, 0, 0, 1};
    cfg(0, 0, 2, 1'b1, 1'b1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; cnten[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) inc_dec[0] = 1'b0;
      step();
      n_total++;
      if (cv(0) !== exp_c[i] || tc[0] !== exp_t[i])
        $display("FAIL sat[%0d] cnt=%0d tc=%b exp cnt=%0d tc=%b", i, cv(0), tc[0], exp_c[i], exp_t[i]);
      else n_pass++;
    end
    cnten[0] = 1'b0;
  endtask

  task automatic test_priority();
    cfg(0, 0, 9, 1'b1, 1'b0);
    clr[0] = 1'b1; load[0] = 1'b1; cnten[0] = 1'b1; load_val[0 +: NB] = 55;
    step();
    n_total++;
    if (cv(0) !== 0 || tc[0] !== 1'b0) $display("FAIL prio_clr_up cnt=%0d tc=%b exp 0/0", cv(0), tc[0]);
    else n_pass++;
    inc_dec[0] = 1'b0;
    step();
    clr[0] = 1'b0;
    n_total++;
    if (cv(0) !== 9) $display("FAIL prio_clr_down cnt=%0d exp 9", cv(0));
    else n_pass++;
    inc_dec[0] = 1'b1; load_val[0 +: NB] = 100;
    step();
    load[0] = 1'b0;
    n_total++;
    if (cv(0) !== 100 || tc[0] !== 1'b0) $display("FAIL prio_load cnt=%0d tc=%b exp 100/0", cv(0), tc[0]);
    else n_pass++;
    step();
    cnten[0] = 1'b0;
    n_total++;
    if (cv(0) !== 0 || tc[0] !== 1'b1) $display("FAIL oor_wrap cnt=%0d tc=%b exp 0/1", cv(0), tc[0]);
    else n_pass++;
    step();
    n_total++;
    if (cv(0) !== 0 || tc[0] !== 1'b0) $display("FAIL hold cnt=%0d tc=%b exp 0/0", cv(0), tc[0]);
    else n_pass++;
  endtask

  task automatic test_isolation();
    cfg(0, 0, 100, 1'b1, 1'b0);
    cfg(1, 8, 4, 1'b1, 1'b0);
    cfg(2, 0, 100, 1'b0, 1'b0);
    cfg(3, 7, 7, 1'b1, 1'b0);
    #1;
    n_total++;
    if (cfg_err !== 4'b0010) $display("FAIL cfg_err got %b exp 0010", cfg_err);
    else n_pass++;
    clr = 4'b1101;
    step();
    clr = '0; cnten = 4'b1111;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_total++;
      if (cv(0) !== k || cv(1) !== 0 || cv(2) !== 100 - k || cv(3) !== 7 || tc !== 4'b1000)
        $display("FAIL iso[%0d] c0=%0d c1=%0d c2=%0d c3=%0d tc=%b exp %0d 0 %0d 7 1000",
                 k, cv(0), cv(1), cv(2), cv(3), tc, k, 100 - k);
      else n_pass++;
    end
    load[1] = 1'b1; load_val[NB +: NB] = 20;
    step();
    load[1] = 1'b0;
    n_total++;
    if (cv(1) !== 20 || cv(0) !== 4 || cv(2) !== 96)
      $display("FAIL iso_load c1=%0d c0=%0d c2=%0d exp 20 4 96", cv(1), cv(0), cv(2));
    else n_pass++;
    step();
    cnten = '0;
    n_total++;
    if (cv(1) !== 20 || tc[1] !== 1'b0) $display("FAIL iso_frozen c1=%0d tc=%b exp 20/0", cv(1), tc[1]);
    else n_pass++;
  endtask

  task automatic test_boundary();
    logic [NB-1:0] ones;
    ones = '1;
    cfg(2, 0, ones, 1'b1, 1'b1);
    load[2] = 1'b1; load_val[2*NB +: NB] = ones - 1;
    step();
    load[2] = 1'b0; cnten[2] = 1'b1;
    step();
    n_total++;
    if (cv(2) !== ones || tc[2] !== 1'b0) $display("FAIL bnd_top cnt=%0h tc=%b exp %0h/0", cv(2), tc[2], ones);
    else n_pass++;
    step();
    n_total++;
    if (cv(2) !== ones || tc[2] !== 1'b1) $display("FAIL bnd_top_sat cnt=%0h tc=%b exp %0h/1", cv(2), tc[2], ones);
    else n_pass++;
    inc_dec[2] = 1'b0; load[2] = 1'b1; load_val[2*NB +: NB] = 0;
    step();
    load[2] = 1'b0;
    step();
    n_total++;
    if (cv(2) !== 0 || tc[2] !== 1'b1) $display("FAIL bnd_zero_sat cnt=%0h tc=%b exp 0/1", cv(2), tc[2]);
    else n_pass++;
    sat_mode[2] = 1'b0;
    step();
    cnten[2] = 1'b0;
    n_total++;
    if (cv(2) !== ones || tc[2] !== 1'b1) $display("FAIL bnd_zero_wrap cnt=%0h tc=%b exp %0h/1", cv(2), tc[2], ones);
    else n_pass++;
  endtask

  task automatic test_prescale();
`ifdef COUNTER_PRESCALE_EN
    logic [NB-1:0] exp_c [6] = '{0, 1, 1, 1, 2, 2};
`else
    logic [NB-1:0] exp_c [6] = '{1, 2, 3, 4, 5, 6};
`endif
    cfg(0, 0, 1000, 1'b1, 1'b0);
    prescale_div = 2; clr[0] = 1'b1;
    step();
    clr[0] = 1'b0; cnten[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_total++;
      if (cv(0) !== exp_c[i]) $display("FAIL prescale[%0d] cnt=%0d exp %0d", i, cv(0), exp_c[i]);
      else n_pass++;
    end
    cnten[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_isolation();
    test_boundary();
    test_prescale();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_multi_channel_counter
